alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Multi-cycle issue controller that drives the 8-bit ALU; it is the initiator end of the ALU op/operand interface.
- Accepts 9-bit instructions over a valid/ready handshake and holds a 4-entry register file.
- Drives ALU operands and op code, then captures the result, carry/shift-out, zero and jump.
- Sequences LW/SW through a memory req/ack handshake and reports completion, branches and illegal ops.

Parameters:
- REG_WIDTH, 8, datapath width (registers, ALU operands, memory data/address).
- OP_WIDTH, 4, ALU op code width.
- RADDR_W, 2, register index width (2**RADDR_W registers); instruction width IW = OP_WIDTH + 2*RADDR_W + 1.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  controller can accept.
- instr  in  IW  [8:5] op, [4:3] ra, [2:1] rb, [0] ld (op 6 only: 1=LW, 0=SW).
- alu_ra / alu_rb  out  REG_WIDTH  ALU operands.
- alu_op  out  OP_WIDTH  ALU op code.
- alu_res / alu_car  in  REG_WIDTH  ALU result / carry-shift-out.
- alu_zero, alu_jump  in  1  ALU flags.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1=store.
- mem_addr, mem_wdata  out  REG_WIDTH  address / store data.
- mem_rdata  in  REG_WIDTH  load data, valid with mem_ack.
- mem_ack  in  1  memory completion.
- done  out  1  one-cycle pulse per retired instruction.
- branch_taken  out  1  one-cycle pulse, coincident with done, for a taken BEQ.
- illegal  out  1  one-cycle pulse, coincident with done, for ops 11-15.
- carry_flag  out  REG_WIDTH  last captured alu_car.
- zero_flag  out  1  last captured alu_zero.
- dbg_sel  in  RADDR_W  debug register select.
- dbg_data  out  REG_WIDTH  combinational read of reg[dbg_sel].

Behaviour:
- Reset (async, rst_n=0): state IDLE; all registers, carry_flag, zero_flag, latched instruction = 0; mem_req, mem_we, done, branch_taken, illegal = 0; instr_ready = 1 once in IDLE.
- Reset mid-operation: same as above immediately; the in-flight instruction is discarded and mem_req drops asynchronously.
- FSM states: IDLE, EXEC, MEM.
- IDLE: instr_ready=1. On valid&&ready, latch instr and go to EXEC. No other state asserts instr_ready.
- EXEC (exactly 1 cycle):
  - alu_op = op; alu_ra = reg[ra]; alu_rb = reg[rb].
  - Outside EXEC/MEM, alu_ra/alu_rb/alu_op are driven 0.
- Commit at the end of EXEC, by op:
  - Ops 0-3: reg[ra] <= alu_res; zero_flag <= alu_zero; carry_flag unchanged. Go to IDLE.
  - Ops 4, 5, 8, 9, 10: same as ops 0-3, plus carry_flag <= alu_car. Go to IDLE.
  - Op 7 (BEQ): no register write; branch_taken <= alu_jump. Go to IDLE. alu_jump is sampled only here; alu_zero is sampled only for register-writing ALU ops.
  - Op 6: go to MEM.
  - Ops 11-15: no state change; illegal <= 1. Go to IDLE.
- MEM:
  - mem_req=1; mem_addr = reg[ra], which is also alu_res with op 6; mem_we = ~ld; mem_wdata = reg[rb].
  - All request signals are stable until ack. Acknowledge is accepted in the same cycle as mem_req, so the minimum MEM length is 1 cycle.
  - On mem_ack: LW writes reg[rb] <= mem_rdata (flags unchanged); SW writes nothing. Go to IDLE.
- done: registered; high for the one cycle after the retiring edge. The controller is in IDLE that cycle and can accept a new instruction in it.
- Throughput: ALU ops, BEQ and illegal ops take 2 cycles per instruction (accept edge, then commit edge); LW/SW take 2 + (MEM cycles).
- Same-index operands (ra==rb) are legal. A write lands on the commit edge and is visible to the next instruction's EXEC; no hazards exist because execution is strictly serial.
- Arithmetic and wrap-around come from the ALU; the controller never modifies alu_res or alu_car widths.
- mem_ack outside MEM is ignored. instr_valid while not ready is ignored; the instruction is not consumed.

Test Plan:
- Reset: hold rst_n=0 mid-MEM with mem_req=1 -> mem_req=0 immediately; after release instr_ready=1, dbg_data=0 for all dbg_sel, flags 0.
- LW r1<-0xF0, LW r2<-0x20 (ack same cycle), then ADD ra=1, rb=2 -> reg1=0x10, carry_flag=0x01, zero_flag=0, a single done pulse 2 cycles after accept.
- SUB ra=2, rb=2 (reg2=0x20) -> reg2=0x00, zero_flag=1. Then BEQ ra=1, rb=1 -> branch_taken and done high in the same cycle, no register change.
- SW ra=1, rb=2 with mem_ack delayed 3 cycles -> mem_req high 3 cycles, mem_we=1, addr/wdata constant, instr_ready=0 throughout, done the cycle after ack.
- Op 12 -> illegal and done pulse, registers and flags unchanged. Op 3 (NOT) on reg0=0x00 -> reg0=0xFF, carry_flag unchanged.
- Back-to-back: instr_valid held high with 3 ALU ops -> accepts spaced 2 cycles apart, each result visible to the next op.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction handshake, ALU operand/result bus and memory request bus
interface alu_issue_ctrl_if #(
    parameter int REG_WIDTH = 8,
    parameter int OP_WIDTH  = 4,
    parameter int RADDR_W   = 2
);
    localparam int IW = OP_WIDTH + 2 * RADDR_W + 1;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [IW-1:0]        instr;
    logic [REG_WIDTH-1:0] alu_ra;
    logic [REG_WIDTH-1:0] alu_rb;
    logic [OP_WIDTH-1:0]  alu_op;
    logic [REG_WIDTH-1:0] alu_res;
    logic [REG_WIDTH-1:0] alu_car;
    logic                 alu_zero;
    logic                 alu_jump;
    logic                 mem_req;
    logic                 mem_we;
    logic [REG_WIDTH-1:0] mem_addr;
    logic [REG_WIDTH-1:0] mem_wdata;
    logic [REG_WIDTH-1:0] mem_rdata;
    logic                 mem_ack;
    modport master (
        input  instr_valid, instr, alu_res, alu_car, alu_zero, alu_jump, mem_rdata, mem_ack,
        output instr_ready, alu_ra, alu_rb, alu_op, mem_req, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        output instr_valid, instr, alu_res, alu_car, alu_zero, alu_jump, mem_rdata, mem_ack,
        input  instr_ready, alu_ra, alu_rb, alu_op, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: serial issue controller driving an external ALU and a req/ack memory port
module alu_issue_ctrl #(
    parameter int REG_WIDTH = 8,
    parameter int OP_WIDTH  = 4,
    parameter int RADDR_W   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_issue_ctrl_if.master     bus,
    output logic                 done_o,
    output logic                 branch_taken_o,
    output logic                 illegal_o,
    output logic [REG_WIDTH-1:0] carry_flag_o,
    output logic                 zero_flag_o,
    input  logic [RADDR_W-1:0]   dbg_sel_i,
    output logic [REG_WIDTH-1:0] dbg_data_o
);
    localparam int IW   = OP_WIDTH + 2 * RADDR_W + 1;
    localparam int NREG = 1 << RADDR_W;

    typedef enum logic [1:0] {IDLE, EXEC, MEM} state_t;

    state_t               state_q;
    logic [IW-1:0]        instr_q;
    logic [REG_WIDTH-1:0] regs_q [NREG];
    logic [REG_WIDTH-1:0] carry_q;
    logic                 zero_q;
    logic                 done_q;
    logic                 br_q;
    logic                 ill_q;

    logic [OP_WIDTH-1:0]  op;
    logic [RADDR_W-1:0]   ra;
    logic [RADDR_W-1:0]   rb;
    logic                 ld;
    logic                 is_mem;
    logic                 is_beq;
    logic                 alu_wr;
    logic                 car_wr;
    logic                 active;
    logic                 in_mem;

    assign op     = instr_q[IW-1 -: OP_WIDTH];
    assign ra     = instr_q[2*RADDR_W -: RADDR_W];
    assign rb     = instr_q[RADDR_W -: RADDR_W];
    assign ld     = instr_q[0];
    assign is_mem = op == OP_WIDTH'(6);
    assign is_beq = op == OP_WIDTH'(7);
    assign alu_wr = (op < OP_WIDTH'(6)) || (op >= OP_WIDTH'(8) && op <= OP_WIDTH'(10));
    assign car_wr = alu_wr && op >= OP_WIDTH'(4);

    assign done_o         = done_q;
    assign branch_taken_o = br_q;
    assign illegal_o      = ill_q;
    assign carry_flag_o   = carry_q;
    assign zero_flag_o    = zero_q;
    assign dbg_data_o     = regs_q[dbg_sel_i];

    // Bus drive: operands only while an instruction is in flight, memory request only in MEM
    always_comb begin
        active          = state_q != IDLE;
        in_mem          = state_q == MEM;
        bus.instr_ready = state_q == IDLE;
        bus.alu_op      = active ? op : '0;
        bus.alu_ra      = active ? regs_q[ra] : '0;
        bus.alu_rb      = active ? regs_q[rb] : '0;
        bus.mem_req     = in_mem;
        bus.mem_we      = in_mem && !ld;
        bus.mem_addr    = in_mem ? regs_q[ra] : '0;
        bus.mem_wdata   = in_mem ? regs_q[rb] : '0;
    end

    // Sequencer: accept in IDLE, commit ALU results in EXEC, wait for ack in MEM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            instr_q <= '0;
            carry_q <= '0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            br_q    <= 1'b0;
            ill_q   <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            br_q   <= 1'b0;
            ill_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.instr_valid) begin
                        instr_q <= bus.instr;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    state_q <= is_mem ? MEM : IDLE;
                    done_q  <= !is_mem;
                    br_q    <= is_beq && bus.alu_jump;
                    ill_q   <= op > OP_WIDTH'(10);
                    if (alu_wr) begin
                        regs_q[ra] <= bus.alu_res;
                        zero_q     <= bus.alu_zero;
                    end
                    if (car_wr) carry_q <= bus.alu_car;
                end
                MEM: begin
                    if (bus.mem_ack) begin
                        if (ld) regs_q[rb] <= bus.mem_rdata;
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed table, reset/back-to-back sequences and random instructions vs a reference model
module tb_alu_issue_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       done, br, ill, zf;
    logic [7:0] cf, dbg_data;
    logic [1:0] dbg_sel = 2'd0;
    int         checks = 0;
    int         passed = 0;
    int         cyc = 0;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .done_o(done), .branch_taken_o(br), .illegal_o(ill),
        .carry_flag_o(cf), .zero_flag_o(zf),
        .dbg_sel_i(dbg_sel), .dbg_data_o(dbg_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] car;
        logic       zero;
        logic       jump;
    } alu_t;

    // Bench-side ALU: the environment the controller drives
    function automatic alu_t alu_f(logic [3:0] op, logic [7:0] a, logic [7:0] b);
        alu_t       r;
        logic [8:0] s;
        s     = {1'b0, a} + {1'b0, b};
        r.car = 8'hA5;
        case (op)
            4'd0: r.res = a & b;
            4'd1: r.res = a | b;
            4'd2: r.res = a ^ b;
            4'd3: r.res = ~a;
            4'd4: begin r.res = s[7:0]; r.car = {7'd0, s[8]}; end
            4'd5: begin r.res = a - b; r.car = {7'd0, a < b}; end
            4'd6: r.res = a;
            4'd7: r.res = a - b;
            4'd8: begin r.res = a << 1; r.car = {7'd0, a[7]}; end
            4'd9: begin r.res = a >> 1; r.car = {7'd0, a[0]}; end
            4'd10: begin r.res = {a[6:0], a[7]}; r.car = {7'd0, a[7]}; end
            default: r.res = 8'h3C;
        endcase
        r.zero = r.res == 8'd0;
        r.jump = a == b;
        return r;
    endfunction

    always_comb begin
        alu_t r;
        r            = alu_f(bus.alu_op, bus.alu_ra, bus.alu_rb);
        bus.alu_res  = r.res;
        bus.alu_car  = r.car;
        bus.alu_zero = r.zero;
        bus.alu_jump = r.jump;
    end

    logic [7:0] m_reg [4];
    logic [7:0] m_car;
    logic       m_zero;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic read_reg(input int idx, output logic [7:0] v);
        dbg_sel = 2'(idx);
        #1 v = dbg_data;
    endtask

    task automatic check_regs();
        logic [7:0] v;
        for (int i = 0; i < 4; i++) begin
            read_reg(i, v);
            chk($sformatf("reg%0d", i), v, m_reg[i]);
        end
        chk("carry_flag", cf, m_car);
        chk("zero_flag", zf, m_zero);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 8'd0;
        m_car  = 8'd0;
        m_zero = 1'b0;
    endtask

    task automatic check_reset();
        chk("rst_ready", bus.instr_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_branch", br, 0);
        chk("rst_illegal", ill, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        check_regs();
    endtask

    // Architectural effect of one instruction, straight from the op table
    task automatic model_step(input logic [8:0] ins, input logic [7:0] rdata, output logic ebr, output logic eill);
        logic [3:0] op;
        logic [1:0] ra, rb;
        alu_t       e;
        op   = ins[8:5];
        ra   = ins[4:3];
        rb   = ins[2:1];
        e    = alu_f(op, m_reg[ra], m_reg[rb]);
        ebr  = 1'b0;
        eill = 1'b0;
        if (op <= 4'd5 || (op >= 4'd8 && op <= 4'd10)) begin
            m_reg[ra] = e.res;
            m_zero    = e.zero;
            if (op >= 4'd4) m_car = e.car;
        end else if (op == 4'd7) ebr = e.jump;
        else if (op == 4'd6) begin
            if (ins[0]) m_reg[rb] = rdata;
        end else eill = 1'b1;
    endtask

    // Issue one instruction from a negedge and follow it to retirement
    task automatic exec(input logic [8:0] ins, input int dly, input logic [7:0] rdata,
                        output logic obr, output logic oill);
        logic [3:0] op;
        logic [7:0] a, b;
        logic       ebr, eill;
        int         n;
        op   = ins[8:5];
        a    = m_reg[ins[4:3]];
        b    = m_reg[ins[2:1]];
        obr  = 1'b0;
        oill = 1'b0;
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        n = 0;
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.instr_ready) begin
            chk("accept_timeout", 0, 1);
            bus.instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        bus.instr = 9'($urandom);
        @(negedge clk);
        chk("exec_alu_op", bus.alu_op, op);
        chk("exec_alu_ra", bus.alu_ra, a);
        chk("exec_alu_rb", bus.alu_rb, b);
        chk("exec_ready", bus.instr_ready, 0);
        if (op == 4'd6) begin
            @(posedge clk);
            for (int k = 1; k <= dly; k++) begin
                @(negedge clk);
                chk("mem_req", bus.mem_req, 1);
                chk("mem_we", bus.mem_we, !ins[0]);
                chk("mem_addr", bus.mem_addr, a);
                chk("mem_wdata", bus.mem_wdata, b);
                chk("mem_ready", bus.instr_ready, 0);
                if (k == dly) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rdata;
                end
                @(posedge clk);
                #1 bus.mem_ack = 1'b0;
                bus.mem_rdata = 8'($urandom);
            end
        end else begin
            bus.mem_ack = 1'($urandom);
            @(posedge clk);
            #1 bus.mem_ack = 1'b0;
        end
        model_step(ins, rdata, ebr, eill);
        @(negedge clk);
        chk("done", done, 1);
        chk("branch_taken", br, ebr);
        chk("illegal", ill, eill);
        chk("retire_ready", bus.instr_ready, 1);
        obr  = br;
        oill = ill;
        check_regs();
        @(negedge clk);
        chk("done_single", done, 0);
    endtask

    typedef struct {
        logic [8:0] ins;
        int         dly;
        logic [7:0] rdata;
        int         idx;
        logic [7:0] val;
        logic [7:0] car;
        logic       zero;
        logic       br;
        logic       ill;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic       obr, oill, ebr, eill;
        logic [7:0] v;
        logic [8:0] seq [3];
        int         acc [3];
        int         n;

        tbl[0] = '{{4'd6, 2'd0, 2'd1, 1'b1}, 1, 8'hF0, 1, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{{4'd6, 2'd0, 2'd2, 1'b1}, 1, 8'h20, 2, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{{4'd4, 2'd1, 2'd2, 1'b0}, 1, 8'h00, 1, 8'h10, 8'h01, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{{4'd5, 2'd2, 2'd2, 1'b0}, 1, 8'h00, 2, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{{4'd7, 2'd1, 2'd1, 1'b0}, 1, 8'h00, 1, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{{4'd6, 2'd1, 2'd2, 1'b0}, 3, 8'hEE, 1, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{{4'd12, 2'd0, 2'd0, 1'b0}, 1, 8'h00, 0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{{4'd6, 2'd0, 2'd3, 1'b1}, 2, 8'h80, 3, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{{4'd8, 2'd3, 2'd3, 1'b0}, 1, 8'h00, 3, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{{4'd3, 2'd0, 2'd0, 1'b0}, 1, 8'h00, 0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0};

        bus.instr_valid = 1'b0;
        bus.instr       = 9'd0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = 8'd0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset();

        for (int i = 0; i < 10; i++) begin
            exec(tbl[i].ins, tbl[i].dly, tbl[i].rdata, obr, oill);
            read_reg(tbl[i].idx, v);
            chk($sformatf("tbl%0d_reg", i), v, tbl[i].val);
            chk($sformatf("tbl%0d_carry", i), cf, tbl[i].car);
            chk($sformatf("tbl%0d_zero", i), zf, tbl[i].zero);
            chk($sformatf("tbl%0d_branch", i), obr, tbl[i].br);
            chk($sformatf("tbl%0d_illegal", i), oill, tbl[i].ill);
        end

        // Reset while a load is parked in MEM
        bus.instr_valid = 1'b1;
        bus.instr       = {4'd6, 2'd0, 2'd1, 1'b1};
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midmem_req_before", bus.mem_req, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("midmem_req_async_drop", bus.mem_req, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset();

        for (int i = 0; i < 40; i++)
            exec(9'($urandom), $urandom_range(1, 3), 8'($urandom), obr, oill);

        // Back-to-back: valid held high, each result feeds the next op
        seq[0] = {4'd4, 2'd0, 2'd1, 1'b0};
        seq[1] = {4'd2, 2'd1, 2'd0, 1'b0};
        seq[2] = {4'd5, 2'd2, 2'd1, 1'b0};
        bus.instr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.instr = seq[k];
            n = 0;
            while (!bus.instr_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_accept", bus.instr_ready, 1);
            acc[k] = cyc;
            if (k > 0) begin
                chk("b2b_done", done, 1);
                chk("b2b_spacing", acc[k] - acc[k-1], 2);
            end
            model_step(seq[k], 8'd0, ebr, eill);
            @(posedge clk);
            #1;
        end
        bus.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_last_done", done, 1);
        check_regs();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
